// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit for the phase-2 datapath
// Optional ILLEGAL_TRAP_EN: illegal opcodes trap to HALT and set the sticky illegal flag.
module control_sequencer #(
    parameter bit MEM_WAIT_EN_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        read,
    output logic        write,
    output logic        BAout,
    output logic        Rin,
    output logic        Rout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        CONN_in,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        incPC,
    output logic        InPortIn,
    output logic        OutPortIn,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHighOut,
    output logic        ZLowOut,
    output logic        MDRout,
    output logic        PCout,
    output logic        InPortOut,
    output logic        Cout,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_RST  = 4'b0000,
        S_STOP = 4'b0001,
        S_T0   = 4'b0111,
        S_T1   = 4'b1000,
        S_T2   = 4'b1001,
        S_T3   = 4'b1010,
        S_T4   = 4'b1011,
        S_T5   = 4'b1100,
        S_T6   = 4'b1101,
        S_HALT = 4'b1111
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls;
    logic [4:0] alu_code;
    logic       mem_ok;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];
    assign mem_ok    = MEM_WAIT_EN_DEFAULT ? mem_ready : 1'b1;
    assign state     = state_q;

    always_comb begin
        cls      = C_ILL;
        alu_code = 5'b00000;
        case (ir[31:27])
            5'b00011: begin cls = C_ALU;    alu_code = 5'b00001; end
            5'b00100: begin cls = C_ALU;    alu_code = 5'b00010; end
            5'b00101: begin cls = C_ALU;    alu_code = 5'b01010; end
            5'b00110: begin cls = C_ALU;    alu_code = 5'b01011; end
            5'b00111: begin cls = C_ALU;    alu_code = 5'b01000; end
            5'b01000: begin cls = C_ALU;    alu_code = 5'b01001; end
            5'b01001: begin cls = C_ALU;    alu_code = 5'b00101; end
            5'b01010: begin cls = C_ALU;    alu_code = 5'b00111; end
            5'b01011: begin cls = C_ALU;    alu_code = 5'b00110; end
            5'b01100: begin cls = C_IMM;    alu_code = 5'b00001; end
            5'b01101: begin cls = C_IMM;    alu_code = 5'b01010; end
            5'b01110: begin cls = C_IMM;    alu_code = 5'b01011; end
            5'b01111: begin cls = C_MULDIV; alu_code = 5'b00100; end
            5'b10000: begin cls = C_MULDIV; alu_code = 5'b00011; end
            5'b10001: begin cls = C_NEGNOT; alu_code = 5'b01100; end
            5'b10010: begin cls = C_NEGNOT; alu_code = 5'b01111; end
            5'b11010: cls = C_NOP;
            5'b11011: cls = C_HALT;
            default:  cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RST;
        else      state_q <= state_d;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                                illegal_q <= 1'b0;
        else if (state_q == S_T2 && cls == C_ILL) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        read      = 1'b0; write    = 1'b0; BAout     = 1'b0; Rin      = 1'b0;
        Rout      = 1'b0; Gra      = 1'b0; Grb       = 1'b0; Grc      = 1'b0;
        CONN_in   = 1'b0; MARin    = 1'b0; MDRin     = 1'b0; HIin     = 1'b0;
        LOin      = 1'b0; Yin      = 1'b0; Zin       = 1'b0; PCin     = 1'b0;
        IRin      = 1'b0; incPC    = 1'b0; InPortIn  = 1'b0; OutPortIn = 1'b0;
        HIout     = 1'b0; LOout    = 1'b0; ZHighOut  = 1'b0; ZLowOut  = 1'b0;
        MDRout    = 1'b0; PCout    = 1'b0; InPortOut = 1'b0; Cout     = 1'b0;
        opcode    = 5'b00000;
        run       = 1'b0;
        case (state_q)
            S_RST: state_d = S_T0;
            S_STOP: if (!stop) state_d = S_T0;
            S_T0: begin
                run = 1'b1;
                // A pending stop diverts before any fetch strobe fires, so PC is untouched
                if (stop) begin
                    state_d = S_STOP;
                end else begin
                    PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                run = 1'b1;
                read = 1'b1; MDRin = 1'b1; ZLowOut = 1'b1;
                if (mem_ok) begin
                    PCin    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                run = 1'b1;
                MDRout = 1'b1; IRin = 1'b1;
                case (cls)
                    C_NOP:  state_d = S_T0;
                    C_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    C_ILL:  state_d = S_HALT;
`else
                    C_ILL:  state_d = S_T0;
`endif
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                run = 1'b1;
                Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                state_d = S_T4;
            end
            S_T4: begin
                run = 1'b1;
                state_d = S_T5;
                case (cls)
                    C_ALU, C_MULDIV: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = alu_code;
                    end
                    C_IMM: begin
                        Cout = 1'b1; Zin = 1'b1; opcode = alu_code;
                    end
                    C_NEGNOT: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = alu_code;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                run = 1'b1;
                ZLowOut = 1'b1;
                if (cls == C_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T6: begin
                run = 1'b1;
                ZHighOut = 1'b1; HIin = 1'b1;
                state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer with a small bus-level datapath model
module tb_control_sequencer;

    localparam logic [3:0] ST_RST = 4'h0, ST_STOP = 4'h1, ST_T0 = 4'h7, ST_T1 = 4'h8,
                           ST_T2 = 4'h9, ST_T3 = 4'hA, ST_T4 = 4'hB, ST_T5 = 4'hC,
                           ST_T6 = 4'hD, ST_HALT = 4'hF;

    localparam logic [27:0] M_READ = 28'd1 << 27, M_RIN = 28'd1 << 24, M_ROUT = 28'd1 << 23,
                            M_GRA = 28'd1 << 22, M_GRB = 28'd1 << 21, M_GRC = 28'd1 << 20,
                            M_MARIN = 28'd1 << 18, M_MDRIN = 28'd1 << 17, M_HIIN = 28'd1 << 16,
                            M_LOIN = 28'd1 << 15, M_YIN = 28'd1 << 14, M_ZIN = 28'd1 << 13,
                            M_PCIN = 28'd1 << 12, M_IRIN = 28'd1 << 11, M_INCPC = 28'd1 << 10,
                            M_ZHI = 28'd1 << 5, M_ZLO = 28'd1 << 4, M_MDROUT = 28'd1 << 3,
                            M_PCOUT = 28'd1 << 2, M_COUT = 28'd1;

    logic clk = 1'b0, clr = 1'b0, mem_ready = 1'b1, stop = 1'b0;
    logic [31:0] ir = 32'd0;
    logic read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin;
    logic Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZHighOut, ZLowOut;
    logic MDRout, PCout, InPortOut, Cout, run, illegal;
    logic [4:0] opcode;
    logic [3:0] state;
    logic [27:0] strb;

    assign strb = {read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin,
                   Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZHighOut,
                   ZLowOut, MDRout, PCout, InPortOut, Cout};

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .read(read), .write(write), .BAout(BAout), .Rin(Rin), .Rout(Rout), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .CONN_in(CONN_in), .MARin(MARin), .MDRin(MDRin), .HIin(HIin),
        .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .incPC(incPC),
        .InPortIn(InPortIn), .OutPortIn(OutPortIn), .HIout(HIout), .LOout(LOout),
        .ZHighOut(ZHighOut), .ZLowOut(ZLowOut), .MDRout(MDRout), .PCout(PCout),
        .InPortOut(InPortOut), .Cout(Cout), .opcode(opcode), .run(run), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    // Datapath model: registers update mid-cycle from the strobes of that cycle
    logic [31:0] rf [16];
    logic [31:0] pc = 32'd0, y = 32'd0, lo = 32'd0, hi = 32'd0, mdr = 32'd0;
    logic [63:0] z = 64'd0;
    logic [15:0] ld_mask = 16'd0;
    logic [31:0] ld_val [16];
    logic [31:0] bus;
    logic [3:0]  sel;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64;
        a64 = {{32{a[31]}}, a};
        b64 = {{32{b[31]}}, b};
        case (op)
            5'b00001: alu = {32'd0, a + b};
            5'b00010: alu = {32'd0, a - b};
            5'b01010: alu = {32'd0, a & b};
            5'b01011: alu = {32'd0, a | b};
            5'b00011: alu = a64 * b64;
            5'b01100: alu = {32'd0, -b};
            5'b01111: alu = {32'd0, ~b};
            default:  alu = 64'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        sel = Gra ? ir[26:23] : Grb ? ir[22:19] : Grc ? ir[18:15] : 4'd0;
        bus = 32'd0;
        if (PCout)    bus = pc;
        if (ZLowOut)  bus = z[31:0];
        if (ZHighOut) bus = z[63:32];
        if (MDRout)   bus = mdr;
        if (Cout)     bus = {{13{ir[18]}}, ir[18:0]};
        if (Rout)     bus = rf[sel];
        if (Zin)      z = incPC ? {32'd0, bus + 32'd1} : alu(opcode, y, bus);
        if (Yin)      y = bus;
        if (PCin)     pc = bus;
        if (Rin)      rf[sel] = bus;
        if (LOin)     lo = bus;
        if (HIin)     hi = bus;
        if (MDRin && read) mdr = ir;
        for (int i = 0; i < 16; i++) if (ld_mask[i]) rf[i] = ld_val[i];
    end

    int n_checks = 0, n_err = 0;
    int n_read, n_pcin, cyc;
    logic [63:0] trace;
    logic [32:0] snap [16];
    logic [31:0] pc0;
    logic [27:0] acc;
    logic run_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_go();
        @(negedge clk);
        #1 ld_mask = 16'd0;
    endtask

    task automatic capture();
        snap[state] = {opcode, strb};
        n_read += int'(read);
        n_pcin += int'(PCin);
    endtask

    // Runs one instruction from T0 until the next T0/HALT/STOP, holding mem_ready low for 'waits' T1 cycles
    task automatic exec(input logic [31:0] word, input int waits, output int cycles);
        int wl;
        bit done;
        wl = waits; done = 0; cycles = 0; trace = 64'd0; n_read = 0; n_pcin = 0;
        for (int i = 0; i < 16; i++) snap[i] = 33'd0;
        ir = word;
        capture();
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            cycles++;
            trace = {trace[59:0], state};
            if (state == ST_T1 && wl > 0) begin
                mem_ready = 1'b0;
                wl--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            capture();
            if (state == ST_T0 || state == ST_HALT || state == ST_STOP) done = 1;
        end
        if (!done) check("exec_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf[i] = 32'd0;
            ld_val[i] = 32'd0;
        end
        step();
        check("rst_state", state, ST_RST);
        check("rst_strobes", strb, 28'd0);
        check("rst_run", run, 0);
        check("rst_illegal", illegal, 0);
        clr = 1'b1;
        step();
        check("t0_state", state, ST_T0);
        check("t0_strobes", {opcode, strb}, {5'b0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN});

        // ori R2, R3, 0x25 with R3 = 5
        ld_val[3] = 32'd5; ld_mask = 16'h0008;
        preload_go();
        exec(32'h71180025, 0, cyc);
        check("ori_trace", trace, 64'h89ABC7);
        check("ori_cycles", cyc, 6);
        check("ori_t1", snap[ST_T1], {5'b0, M_READ | M_MDRIN | M_ZLO | M_PCIN});
        check("ori_t2", snap[ST_T2], {5'b0, M_MDROUT | M_IRIN});
        check("ori_t3", snap[ST_T3], {5'b0, M_GRB | M_ROUT | M_YIN});
        check("ori_t4", snap[ST_T4], {5'b01011, M_COUT | M_ZIN});
        check("ori_t5", snap[ST_T5], {5'b0, M_ZLO | M_GRA | M_RIN});
        check("ori_r2", rf[2], 32'd37);

        // add R1, R2, R3 with R2 = 7, R3 = 9
        ld_val[2] = 32'd7; ld_val[3] = 32'd9; ld_mask = 16'h000C;
        preload_go();
        exec(32'h18918000, 0, cyc);
        check("add_cycles", cyc, 6);
        check("add_t4", snap[ST_T4], {5'b00001, M_GRC | M_ROUT | M_ZIN});
        check("add_r1", rf[1], 32'd16);

        // mul R3, R4 with R3 = 6, R4 = -3
        ld_val[3] = 32'd6; ld_val[4] = 32'hFFFFFFFD; ld_mask = 16'h0018;
        preload_go();
        exec(32'h801A0000, 0, cyc);
        check("mul_trace", trace, 64'h89ABCD7);
        check("mul_cycles", cyc, 7);
        check("mul_t4", snap[ST_T4], {5'b00011, M_GRC | M_ROUT | M_ZIN});
        check("mul_t5", snap[ST_T5], {5'b0, M_ZLO | M_LOIN});
        check("mul_t6", snap[ST_T6], {5'b0, M_ZHI | M_HIIN});
        check("mul_lo", lo, 32'hFFFFFFEE);
        check("mul_hi", hi, 32'hFFFFFFFF);

        // Memory wait: three not-ready cycles in T1 on a nop fetch
        pc0 = pc;
        exec(32'hD0000000, 3, cyc);
        check("wait_trace", trace, 64'h888897);
        check("wait_read_cycles", n_read, 4);
        check("wait_pcin_pulses", n_pcin, 1);
        check("wait_pc_step", pc, pc0 + 32'd1);

        // Asynchronous clear in T4 of an add
        ld_val[1] = 32'h55; ld_val[2] = 32'd7; ld_val[3] = 32'd9; ld_mask = 16'h000E;
        preload_go();
        ir = 32'h18918000;
        for (int i = 0; i < 10 && state != ST_T4; i++) step();
        check("clr_reached_t4", state, ST_T4);
        #1 clr = 1'b0;
        #1;
        check("clr_state", state, ST_RST);
        check("clr_strobes", {opcode, strb}, 33'd0);
        check("clr_run", run, 0);
        stop = 1'b1;
        step();
        check("clr_r1_kept", rf[1], 32'h55);

        // Stop honoured on T0 entry, then resume with a nop
        clr = 1'b1;
        step();
        check("stop_t0_state", state, ST_T0);
        check("stop_t0_strobes", strb, 28'd0);
        step();
        check("stop_state", state, ST_STOP);
        check("stop_run", run, 0);
        step();
        step();
        check("stop_hold", {state, strb}, {ST_STOP, 28'd0});
        stop = 1'b0;
        step();
        check("stop_resume", state, ST_T0);
        exec(32'hD0000000, 0, cyc);
        check("nop_trace", trace, 64'h897);
        check("nop_cycles", cyc, 3);

        // halt holds for 20 cycles with nothing driven
        exec(32'hD8000000, 0, cyc);
        check("halt_trace", trace, 64'h89F);
        acc = 28'd0;
        run_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            acc |= strb;
            run_seen |= run;
        end
        check("halt_strobes", acc, 28'd0);
        check("halt_run", run_seen, 0);
        check("halt_state", state, ST_HALT);

        clr = 1'b0;
        step();
        clr = 1'b1;
        step();
        check("refetch_t0", state, ST_T0);
        exec(32'hF8000000, 0, cyc);
`ifdef ILLEGAL_TRAP_EN
        check("illegal_trace", trace, 64'h89F);
        check("illegal_flag", illegal, 1);
`else
        check("illegal_trace", trace, 64'h897);
        check("illegal_flag", illegal, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the phase-2 datapath.
- Sequences fetch (T0–T2) and execute (T3–T6) for ALU register, ALU immediate, mul/div, neg/not, nop and halt instructions.
- Replaces the hand-driven T-state stimulus in benches.
- Sits beside the datapath: reads IR, drives every datapath control strobe and the 5-bit ALU opcode.

Parameters:
- MEM_WAIT_EN_DEFAULT, 1, when 1 T1 waits on mem_ready; when 0 T1 always lasts one cycle.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- ir  in  32  instruction register contents from datapath
- mem_ready  in  1  memory read data valid
- stop  in  1  pause request, honoured only at instruction boundary
- read, write, BAout, Rin, Rout, Gra, Grb, Grc, CONN_in, MARin, MDRin, HIin, LOin, Yin, Zin, PCin, IRin, incPC, InPortIn, OutPortIn, HIout, LOout, ZHighOut, ZLowOut, MDRout, PCout, InPortOut, Cout  out  1 each  datapath strobes
- opcode  out  5  ALU operation: nop 00000, add 00001, sub 00010, mul 00011, div 00100, shr 00101, shl 00110, shra 00111, ror 01000, rol 01001, and 01010, or 01011, neg 01100, not 01111
- run  out  1  high while executing
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state, for debug

Behaviour:
- Instruction opcode is ir[31:27]:
  - add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000, neg 10001, not 10010
  - nop 11010, halt 11011
  - all others illegal
- States (4-bit encoding): RST 0000, T0 0111, T1 1000, T2 1001, T3 1010, T4 1011, T5 1100, T6 1101, STOP 0001, HALT 1111.
- Strobes and opcode are decoded combinationally from the registered state plus ir[31:27]. Any strobe not listed for a state is 0.
- clr low: state=RST immediately; all strobes 0, opcode 00000, run=0, illegal=0. Applies mid-instruction too; no partial writes are completed.
- RST: first clk with clr high → T0.
- T0: PCout, MARin, incPC, Zin.
  - stop=1 on entry cycle → STOP instead, with no strobes asserted.
- STOP: run=0, all strobes 0; returns to T0 when stop=0.
- T1: ZLowOut, PCin, read, MDRin.
  - Stays in T1 until mem_ready=1; PCin is asserted only in the exit cycle so PC increments exactly once.
  - Exit to T2 in the cycle mem_ready=1.
- T2: MDRout, IRin.
  - Next state is decoded from the incoming word: nop → T0, halt → HALT, illegal → T0 (see feature), else → T3.
- T3: Grb, Rout, Yin.
- T4 by instruction class:
  - Register ALU, mul, div: Grc, Rout, Zin, opcode = mapped ALU code.
  - Immediate: Cout, Zin, opcode = add/and/or.
  - neg/not: Grb, Rout, Zin, opcode.
- T5:
  - ALU classes: ZLowOut, Gra, Rin → T0.
  - mul/div: ZLowOut, LOin → T6.
- T6: ZHighOut, HIin → T0.
- HALT: all strobes 0, run=0; exits only via clr.
- run=1 in T0–T6.
- Latencies with mem_ready tied high: ALU instructions take 6 cycles, mul/div 7, nop 3.
- write, BAout, CONN_in, InPort*, OutPortIn, HIout, LOout are held 0 in this phase.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in T2 goes to HALT and sets illegal=1, which holds until clr.
- Undefined: illegal opcodes execute as nop (T2 → T0), and illegal stays 0.

Test Plan:
- ori 0x71180025, R3=5, mem_ready=1:
  - States T0,T1,T2,T3,T4,T5 then T0.
  - In T4, Cout=1 and opcode=01011.
  - R2=37 after T5.
- add 0x18918000, R2=7, R3=9: T4 has Grc=1, Rout=1, opcode=00001; R1=16 after T5.
- mul 0x801A0000, R3=6, R4=−3: T5 has LOin=1, T6 has HIin=1; LO=0xFFFFFFEE, HI=0xFFFFFFFF, 7 cycles total.
- mem_ready held low 3 cycles in T1: read and MDRin stay high 4 cycles, PCin pulses once, PC advances by exactly 1.
- halt 0xD8000000: HALT after T2, run=0, strobes stay 0 for 20 cycles. Same for stop=1 at T0, except STOP is entered and execution resumes when stop=0.
- clr pulsed low during T4 of an add: outputs go 0 with no clock edge, destination register unchanged, refetch begins from RST. Illegal 0xF8000000 gives illegal=1 and HALT with ILLEGAL_TRAP_EN defined, otherwise execution as nop.
